// File: rtl/smpc_pad_scan.sv
// Saturn SMPC digital-pad scanner: walks the four TH/TR select phases, samples D3..D0
// after a settle delay and publishes the assembled 16-bit pad word once per scan.
module smpc_pad_scan #(
  parameter int unsigned SETTLE = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        START,
  input  logic [6:0]  PI,
  output logic [6:0]  PO,
  output logic [6:0]  PDIR,
  output logic [15:0] JOY,
  output logic        CONNECTED,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  logic [6:0]  sync1_r;
  logic [6:0]  sync2_r;
  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [1:0]  phase_r;
  logic [1:0]  sel_r;
  logic [15:0] buf_r;
  logic [15:0] joy_r;
  logic        conn_r;
  logic        busy_r;
  logic        done_r;
  logic        unused_s;

  // {TH,TR} select pattern that addresses each nibble of the pad
  function automatic logic [1:0] phase_sel(input logic [1:0] ph);
    logic [1:0] sel;
    case (ph)
      2'd0:    sel = 2'b01;
      2'd1:    sel = 2'b10;
      2'd2:    sel = 2'b00;
      default: sel = 2'b11;
    endcase
    return sel;
  endfunction

  // Two-flop synchronizer, free-running on every CLK regardless of CE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 7'h7F;
      sync2_r <= 7'h7F;
    end else begin
      sync1_r <= PI;
      sync2_r <= sync1_r;
    end
  end

  // Scan sequencer; DONE is cleared on every CLK so it never outlives one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      phase_r <= 2'd0;
      sel_r   <= 2'b11;
      buf_r   <= 16'hFFFF;
      joy_r   <= 16'hFFFF;
      conn_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (CE) begin
        case (state_r)
          ST_IDLE: begin
            if (START) begin
              phase_r <= 2'd0;
              sel_r   <= phase_sel(2'd0);
              cnt_r   <= RELOAD;
              busy_r  <= 1'b1;
              state_r <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt_r == 8'd0) begin
              state_r <= ST_SAMPLE;
            end else begin
              cnt_r <= cnt_r - 8'd1;
            end
          end
          ST_SAMPLE: begin
            case (phase_r)
              2'd0:    buf_r[15:12] <= sync2_r[3:0];
              2'd1:    buf_r[11:8]  <= sync2_r[3:0];
              2'd2:    buf_r[7:4]   <= sync2_r[3:0];
              default: buf_r[3:0]   <= sync2_r[3:0];
            endcase
            if (phase_r != 2'd3) begin
              phase_r <= phase_r + 2'd1;
              sel_r   <= phase_sel(phase_r + 2'd1);
              cnt_r   <= RELOAD;
              state_r <= ST_SETTLE;
            end else begin
              sel_r   <= 2'b11;
              state_r <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            // ID bits 100 identify a standard digital pad
            if (buf_r[2:0] == 3'b100) begin
              joy_r  <= buf_r;
              conn_r <= 1'b1;
            end else begin
              joy_r  <= 16'hFFFF;
              conn_r <= 1'b0;
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            phase_r <= 2'd0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign unused_s  = ^sync2_r[6:4];
  assign PO        = {sel_r, 5'b00000};
  assign PDIR      = 7'b1100000;
  assign JOY       = joy_r;
  assign CONNECTED = conn_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_smpc_pad_scan.sv
// Self-checking bench for smpc_pad_scan: a pad model answers the TH/TR selects and
// each scan is compared against the pad-word rules, select timing and handshake.
module tb_smpc_pad_scan;

  localparam int S     = 4;
  localparam int TICKS = 4 * (S + 1) + 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        START;
  logic [6:0]  PI;
  logic [6:0]  PO;
  logic [6:0]  PDIR;
  logic [15:0] JOY;
  logic        CONNECTED;
  logic        BUSY;
  logic        DONE;

  logic [3:0]  pad_nib [4];
  logic [3:0]  nib_s;
  logic [15:0] last_joy;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ce_mode  = 0;

  typedef struct {
    logic [15:0] nibs;
    int          mode;
    logic [15:0] joy;
    logic        conn;
  } vec_t;

  vec_t vecs [6];

  smpc_pad_scan #(.SETTLE(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .PI(PI),
    .PO(PO), .PDIR(PDIR), .JOY(JOY), .CONNECTED(CONNECTED),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Pad model: the nibble returned depends on the current {TH,TR}
  always_comb begin
    case (PO[6:5])
      2'b01:   nib_s = pad_nib[0];
      2'b10:   nib_s = pad_nib[1];
      2'b00:   nib_s = pad_nib[2];
      default: nib_s = pad_nib[3];
    endcase
  end
  assign PI = {PO[6:5], 1'b1, nib_s};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pad(input logic [15:0] w);
    pad_nib[0] = w[15:12];
    pad_nib[1] = w[11:8];
    pad_nib[2] = w[7:4];
    pad_nib[3] = w[3:0];
  endtask

  function automatic logic next_ce();
    if (ce_mode == 0) return 1'b1;
    if (ce_mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] exp_sel(input int k);
    int ph;
    ph = k / (S + 1);
    case (ph)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [15:0] model_joy(input logic [15:0] nibs);
    return (nibs[2:0] == 3'b100) ? nibs : 16'hFFFF;
  endfunction

  task automatic step(input logic ce_v);
    CE = ce_v;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // One full scan from request to DONE, checking every observable along the way
  task automatic do_scan(input string name, input logic [15:0] exp_joy, input logic exp_conn,
                         input bit keep_start, input int repulse);
    int k, steps, sel_err, busy_err, joy_err, pin_err, done_cnt, done_k;
    logic c;
    k = -1; steps = 0; sel_err = 0; busy_err = 0; joy_err = 0; pin_err = 0;
    done_cnt = 0; done_k = -1;
    START = 1'b1;
    while (k < 0 && steps < 1000) begin
      c = next_ce();
      step(c);
      steps++;
      if (c) k = 0;
    end
    if (!keep_start) START = 1'b0;
    while (k >= 0 && k < TICKS - 1 && steps < 4000) begin
      if (PO[6:5] !== exp_sel(k)) sel_err++;
      if (BUSY !== 1'b1) busy_err++;
      if (JOY !== last_joy) joy_err++;
      if (PO[4:0] !== 5'b0 || PDIR !== 7'b1100000) pin_err++;
      c = next_ce();
      if (c && repulse == k + 1) START = 1'b1;
      else if (!keep_start) START = 1'b0;
      step(c);
      steps++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_k = c ? k + 1 : -99;
      end
      if (c) k++;
    end
    if (!keep_start) START = 1'b0;
    check({name, "_ticks"}, 32'(k), 32'(TICKS - 1));
    check({name, "_sel_seq_errs"}, 32'(sel_err), 32'd0);
    check({name, "_busy_errs"}, 32'(busy_err), 32'd0);
    check({name, "_joy_partial_errs"}, 32'(joy_err), 32'd0);
    check({name, "_pin_errs"}, 32'(pin_err), 32'd0);
    check({name, "_done_tick"}, 32'(done_k), 32'(TICKS - 1));
    check({name, "_busy_end"}, 32'(BUSY), 32'd0);
    check({name, "_sel_idle"}, 32'(PO[6:5]), 32'h3);
    check({name, "_joy"}, 32'(JOY), 32'(exp_joy));
    check({name, "_conn"}, 32'(CONNECTED), 32'(exp_conn));
    step(1'b0);
    if (DONE === 1'b1) done_cnt++;
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_joy_hold"}, 32'(JOY), 32'(exp_joy));
    last_joy = exp_joy;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{nibs: 16'hEFFC, mode: 0, joy: 16'hEFFC, conn: 1'b1};
    vecs[1] = '{nibs: 16'hFFFF, mode: 0, joy: 16'hFFFF, conn: 1'b0};
    vecs[2] = '{nibs: 16'hEFFC, mode: 1, joy: 16'hEFFC, conn: 1'b1};
    vecs[3] = '{nibs: 16'h0004, mode: 0, joy: 16'h0004, conn: 1'b1};
    vecs[4] = '{nibs: 16'h1235, mode: 1, joy: 16'hFFFF, conn: 1'b0};
    vecs[5] = '{nibs: 16'hA53C, mode: 2, joy: 16'hA53C, conn: 1'b1};

    RST_N = 1'b1; CE = 1'b0; START = 1'b0;
    set_pad(16'hFFFF);
    last_joy = 16'hFFFF;
    #1 RST_N = 1'b0;
    step(1'b1);
    step(1'b1);
    check("rst_po", 32'(PO), 32'h60);
    check("rst_pdir", 32'(PDIR), 32'h60);
    check("rst_joy", 32'(JOY), 32'hFFFF);
    check("rst_conn", 32'(CONNECTED), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RST_N = 1'b1;
    step(1'b1);

    for (int i = 0; i < 6; i++) begin
      ce_mode = vecs[i].mode;
      set_pad(vecs[i].nibs);
      do_scan($sformatf("vec%0d", i), vecs[i].joy, vecs[i].conn, 1'b0, -1);
      step(1'b1);
    end

    // Second START mid-scan must neither restart nor queue a scan
    ce_mode = 0;
    set_pad(16'hEFFC);
    do_scan("repulse", 16'hEFFC, 1'b1, 1'b0, 7);
    step(1'b1);
    step(1'b1);
    check("repulse_no_queue", 32'(BUSY), 32'd0);

    // Reset during phase 2
    set_pad(16'h0004);
    START = 1'b1;
    step(1'b1);
    START = 1'b0;
    for (int i = 0; i < 11; i++) step(1'b1);
    check("pre_rst_sel_ph2", 32'(PO[6:5]), 32'h0);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_po", 32'(PO), 32'h60);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_joy", 32'(JOY), 32'hFFFF);
    check("midrst_conn", 32'(CONNECTED), 32'd0);
    step(1'b1);
    #2 RST_N = 1'b1;
    last_joy = 16'hFFFF;
    for (int i = 0; i < 5; i++) step(1'b1);
    check("postrst_no_resume", 32'(BUSY), 32'd0);
    check("postrst_joy", 32'(JOY), 32'hFFFF);
    set_pad(16'hEFFC);
    do_scan("postrst", 16'hEFFC, 1'b1, 1'b0, -1);
    step(1'b1);

    // START held: back-to-back scans, pad changes after the first
    set_pad(16'hEFFC);
    do_scan("b2b1", 16'hEFFC, 1'b1, 1'b1, -1);
    pad_nib[0] = 4'h7;
    do_scan("b2b2", 16'h7FFC, 1'b1, 1'b1, -1);
    do_scan("b2b3", 16'h7FFC, 1'b1, 1'b1, -1);
    START = 1'b0;
    step(1'b1);
    step(1'b1);
    check("b2b_stop", 32'(BUSY), 32'd0);

    // Randomized pads and CE patterns against the pad-word rule
    ce_mode = 2;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[2:0] = 3'b100;
      set_pad(w);
      do_scan($sformatf("rnd%0d", i), model_joy(w), w[2:0] == 3'b100, 1'b0, -1);
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smpc_pad_scan.md
SMPC_PAD_SCAN -- requirements
Module: smpc_pad_scan

Interface
REQ-001 SETTLE parameter, default 32; number of CE ticks the select lines are held before each sample, legal range 1..255.
REQ-002 CLK input 1: system clock.
REQ-003 RST_N input 1: reset, asynchronous, active-low.
REQ-004 CE input 1: clock enable; all state advances only on CLK edges with CE=1, except the input synchronizer.
REQ-005 START input 1: scan request, sampled on CE ticks.
REQ-006 PI input 7: peripheral port pins; [3:0]=D3..D0, [4]=TL, [5]=TR, [6]=TH.
REQ-007 PO output 7: port drive values.
REQ-008 PDIR output 7: port direction, 1=driven by this block.
REQ-009 JOY output 16: assembled raw pad word, active-low buttons, consumed by the SMPC INTBACK path.
REQ-010 CONNECTED output 1: standard digital pad detected on the last completed scan.
REQ-011 BUSY output 1: scan in progress.
REQ-012 DONE output 1: one-CLK pulse marking a completed scan.

Function
REQ-013 PI shall pass through a 2-flop synchronizer clocked every CLK, independent of CE; all samples shall use the synchronized value.
REQ-014 PDIR shall be constant 7'b1100000, driving TH and TR only.
REQ-015 PO[4:0] shall be 0; PO[6:5] shall be {TH,TR}, equal to 2'b11 whenever the block is not scanning.
REQ-016 The FSM shall have states IDLE, SETTLE, SAMPLE and FINISH.
REQ-017 IDLE: on a CE tick with START=1, the block shall set phase=0, drive the phase-0 select, load the counter with SETTLE-1, assert BUSY and go to SETTLE.
REQ-018 Phase select order {TH,TR}: phase0=01, phase1=10, phase2=00, phase3=11.
REQ-019 SETTLE: the counter shall decrement each CE tick; on reaching 0 the FSM shall go to SAMPLE.
REQ-020 SAMPLE: the block shall latch D3..D0 into a nibble buffer: phase0->[15:12] (Right,Left,Down,Up), phase1->[11:8] (Start,A,C,B), phase2->[7:4] (R,X,Y,Z), phase3->[3:0] (L,ID2..ID0).
REQ-021 SAMPLE with phase<3: the block shall increment phase, drive the next select, reload the counter with SETTLE-1 and return to SETTLE.
REQ-022 SAMPLE with phase=3: the FSM shall go to FINISH and drive select 11.
REQ-023 Each phase shall therefore take SETTLE+1 CE ticks, with the select stable for SETTLE ticks before the sample.
REQ-024 FINISH, connected case: if buffer[2:0]==3'b100, JOY<=buffer and CONNECTED<=1.
REQ-025 FINISH, not-connected case: otherwise JOY<=16'hFFFF and CONNECTED<=0.
REQ-026 FINISH shall also pulse DONE for exactly one CLK, deassert BUSY on the same edge and return to IDLE.
REQ-027 START while BUSY shall be ignored and shall not queue; START held high shall cause back-to-back scans, with a new scan starting the first CE tick after FINISH.
REQ-028 JOY and CONNECTED shall change only in FINISH; partial scans shall never be visible on JOY.
REQ-029 CE=0 shall freeze the FSM, the counter and all outputs; DONE shall be 0 on non-CE cycles.

Reset
REQ-030 RST_N low shall immediately force the following, including mid-scan: state=IDLE, PO=7'b1100000, PDIR=7'b1100000, JOY=16'hFFFF, CONNECTED=0, BUSY=0, DONE=0, counter=0, phase=0, synchronizer=7'h7F.
REQ-031 After RST_N rises, the block shall wait for START; the interrupted scan shall not resume.

Verification
REQ-032 SETTLE=4, CE=1, pad model returns phase nibbles 0xE,0xF,0xF,0xC, one START pulse -> TH/TR sequence 01,10,00,11; DONE at 20 CE ticks + FINISH; JOY=16'hEFFC; CONNECTED=1.
REQ-033 All PI D bits =1 (no pad), START -> JOY=16'hFFFF, CONNECTED=0, DONE pulses once.
REQ-034 CE every 3rd CLK, same pad as REQ-032 -> identical JOY; each select held exactly 4 CE ticks; DONE width 1 CLK.
REQ-035 START pulsed again at tick 7 of a scan -> ignored; exactly one DONE; BUSY continuous from start to FINISH.
REQ-036 RST_N asserted during phase 2 -> PO=7'b1100000 and BUSY=0 immediately; JOY=16'hFFFF; a new START yields a full 4-phase scan.
REQ-037 START held high for 3 scans with the pad changing to phase0 nibble 0x7 after scan 1 -> scan 1 JOY=16'hEFFC; scans 2 and 3 JOY=16'h7FFC; no idle gap beyond one CE tick.
